// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared defaults and per-key FSM state encoding for key_debounce
package key_pkg;

    localparam int KEY_W_DEF   = 4;
    localparam int CNT_MAX_DEF = 1_000_000;

    typedef enum logic [1:0] {
        UP      = 2'd0,
        FILT_DN = 2'd1,
        DOWN    = 2'd2,
        FILT_UP = 2'd3
    } key_st_e;

endpackage

// File: rtl/key_filter.sv
// rtl/key_filter.sv - one key's debounce FSM, stability counter and event pulses
module key_filter
    import key_pkg::*;
#(
    parameter int CNT_MAX = CNT_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic sync,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic press_nxt
);

    localparam int                CNT_W    = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CNT_MAX - 1);

    key_st_e          st;
    logic [CNT_W-1:0] cnt;

    // Lets the top register any_press on the same edge that key_press rises.
    assign press_nxt = !rst && (st == FILT_DN) && !sync && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= UP;
            cnt         <= '0;
            key_state   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            case (st)
                UP: begin
                    if (!sync) begin
                        st  <= FILT_DN;
                        cnt <= '0;
                    end
                end
                FILT_DN: begin
                    if (sync) begin
                        st  <= UP;
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        st        <= DOWN;
                        cnt       <= '0;
                        key_state <= 1'b1;
                        key_press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DOWN: begin
                    if (sync) begin
                        st  <= FILT_UP;
                        cnt <= '0;
                    end
                end
                FILT_UP: begin
                    if (!sync) begin
                        st  <= DOWN;
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        st          <= UP;
                        cnt         <= '0;
                        key_state   <= 1'b0;
                        key_release <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    st  <= UP;
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronizes active-low key pins and debounces each key independently
module key_debounce
    import key_pkg::*;
#(
    parameter int KEY_W   = KEY_W_DEF,
    parameter int CNT_MAX = CNT_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key,
    output logic [KEY_W-1:0] key_state,
    output logic [KEY_W-1:0] key_press,
    output logic [KEY_W-1:0] key_release,
    output logic             any_press
);

    logic [KEY_W-1:0] sync_q1;
    logic [KEY_W-1:0] sync_q2;
    logic [KEY_W-1:0] press_nxt;

    // Reset to all ones so released keys never look like a press afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= '1;
            sync_q2 <= '1;
        end else begin
            sync_q1 <= key;
            sync_q2 <= sync_q1;
        end
    end

    for (genvar i = 0; i < KEY_W; i++) begin : g_key
        key_filter #(
            .CNT_MAX (CNT_MAX)
        ) u_filter (
            .clk         (clk),
            .rst         (rst),
            .sync        (sync_q2[i]),
            .key_state   (key_state[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .press_nxt   (press_nxt[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            any_press <= 1'b0;
        end else begin
            any_press <= |press_nxt;
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - scoreboard bench for key_debounce with CNT_MAX = 8
module tb_key_debounce;

    localparam int KEY_W   = 4;
    localparam int CNT_MAX = 8;
    localparam int LAT     = CNT_MAX + 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [KEY_W-1:0] key = '1;
    logic [KEY_W-1:0] key_state;
    logic [KEY_W-1:0] key_press;
    logic [KEY_W-1:0] key_release;
    logic             any_press;

    typedef struct {
        int               cyc;
        logic [KEY_W-1:0] press;
        logic [KEY_W-1:0] rel;
    } exp_t;

    exp_t sb[$];
    int   edge_no   = 0;
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   bad_state = 0;

    key_debounce #(
        .KEY_W   (KEY_W),
        .CNT_MAX (CNT_MAX)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .key         (key),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release),
        .any_press   (any_press)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, act, exp, edge_no);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Key change driven now is first sampled on the next edge; pulse lands LAT edges from now.
    task automatic expect_evt(input logic [KEY_W-1:0] press, input logic [KEY_W-1:0] rel);
        exp_t e;
        e.cyc   = edge_no + LAT;
        e.press = press;
        e.rel   = rel;
        sb.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            edge_no++;
            #1;
            if ((key_press != '0) || (key_release != '0) || any_press) begin
                check_eq("press_release_overlap", 32'(key_press & key_release), 32'd0);
                if (sb.size() == 0) begin
                    check_eq("unexpected_event", {key_press, key_release, 3'b000, any_press}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("event_edge", 32'(edge_no), 32'(e.cyc));
                    check_eq("key_press", 32'(key_press), 32'(e.press));
                    check_eq("key_release", 32'(key_release), 32'(e.rel));
                    check_eq("any_press", 32'(any_press), 32'(e.press != '0));
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        key = '1;
        step(3);
        check_eq("reset_state", 32'(key_state), 32'd0);
        check_eq("reset_press", 32'(key_press), 32'd0);
        check_eq("reset_release", 32'(key_release), 32'd0);
        check_eq("reset_any", 32'(any_press), 32'd0);
        rst = 1'b0;
        step(5);

        // Single press and release on key 0
        key[0] = 1'b0;
        expect_evt(4'b0001, 4'b0000);
        step(15);
        check_eq("k0_held_state", 32'(key_state), 32'h1);
        key[0] = 1'b1;
        expect_evt(4'b0000, 4'b0001);
        step(15);
        check_eq("k0_released_state", 32'(key_state), 32'h0);

        // Bounce on key 1 shorter than the filter window: no events at all
        for (int i = 0; i < 14; i++) begin
            key[1] = ~key[1];
            step(3);
        end
        key[1] = 1'b1;
        step(20);
        check_eq("k1_bounce_state", 32'(key_state), 32'h0);

        // Key 2 release with a bounce before settling high
        key[2] = 1'b0;
        expect_evt(4'b0100, 4'b0000);
        step(15);
        check_eq("k2_held_state", 32'(key_state), 32'h4);
        key[2] = 1'b1;
        step(5);
        key[2] = 1'b0;
        step(2);
        check_eq("k2_bounce_held", 32'(key_state), 32'h4);
        key[2] = 1'b1;
        expect_evt(4'b0000, 4'b0100);
        step(15);
        check_eq("k2_released_state", 32'(key_state), 32'h0);

        // All keys together
        key = 4'b0000;
        expect_evt(4'b1111, 4'b0000);
        step(15);
        check_eq("all_held_state", 32'(key_state), 32'hF);
        key = 4'b1111;
        expect_evt(4'b0000, 4'b1111);
        step(15);
        check_eq("all_released_state", 32'(key_state), 32'h0);

        // Reset mid-filter while key 0 stays low: filter restarts from scratch
        key[0] = 1'b0;
        step(7);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_eq("midfilter_reset_state", 32'(key_state), 32'h0);
        expect_evt(4'b0001, 4'b0000);
        step(20);
        check_eq("post_reset_held_state", 32'(key_state), 32'h1);
        key[0] = 1'b1;
        expect_evt(4'b0000, 4'b0001);
        step(15);

        // Long hold on key 3
        key[3] = 1'b0;
        expect_evt(4'b1000, 4'b0000);
        step(12);
        for (int i = 0; i < 10000; i++) begin
            if (key_state[3] !== 1'b1) bad_state++;
            step(1);
        end
        check_eq("k3_long_hold_drops", 32'(bad_state), 32'd0);
        key[3] = 1'b1;
        expect_evt(4'b0000, 4'b1000);
        step(15);
        check_eq("k3_released_state", 32'(key_state), 32'h0);

        step(5);
        check_eq("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
